// File: rtl/mem_burst_reader_pkg.sv
// Shared types and default widths for the burst reader.
// FSM encoding lives here so the bench and RTL agree on state names.
package mem_burst_reader_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_burst_reader_fifo.sv
// Small synchronous FIFO buffering read data between memory and consumer.
// Simultaneous push and pop is accepted even when full.
module burst_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 2,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full,
  output logic [CW-1:0]         count
);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr;
  logic [PW-1:0]         r_rd;
  logic [CW-1:0]         r_count;
  logic                  w_pop;
  logic                  w_push;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(FIFO_DEPTH));
  assign count  = r_count;
  assign dout   = r_mem[r_rd];
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read master: streams `length` words from base upward to a
// valid/ready consumer, throttling issue so the FIFO cannot overflow.
module mem_burst_reader
  import mem_burst_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] baseAddress,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic                  memWriteEnable,
  input  logic [DATA_WIDTH-1:0] memReadData,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outValid,
  input  logic                  outReady
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic [ADDR_WIDTH-1:0] r_remaining;
  logic                  r_inflight;
  logic                  w_issue;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_full;
  logic [CW-1:0]         w_count;
  logic [CW:0]           w_occ;

  burst_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (r_inflight),
    .pop   (w_pop),
    .din   (memReadData),
    .dout  (outData),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

  assign outValid       = !w_empty;
  assign w_pop          = outValid && outReady;
  assign busy           = (r_state != ST_IDLE);
  assign done           = (r_state == ST_DONE);
  assign memAddress     = r_mem_addr;
  assign memWriteEnable = 1'b0;

  // Buffered words plus the one in flight must leave a free slot.
  assign w_occ = {1'b0, w_count}
               + (CW+1)'(r_inflight)
               - (CW+1)'(w_pop);
  assign w_issue = (r_state == ST_FETCH)
                && (w_occ < (CW+1)'(FIFO_DEPTH))
                && (!w_full || w_pop);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = (length == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (w_issue && r_remaining == ADDR_WIDTH'(1)) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!r_inflight && w_empty) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_mem_addr  <= '0;
      r_next_addr <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_issue;
      if (r_state == ST_IDLE && start) begin
        r_next_addr <= baseAddress;
        r_remaining <= length;
      end
      if (w_issue) begin
        r_mem_addr  <= r_next_addr;
        r_next_addr <= r_next_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench: burst reader against a behavioural port-B memory.
// Expected words come from the bench's own preload values.
module tb_mem_burst_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] baseAddress;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic [15:0] memAddress;
  logic        memWriteEnable;
  logic [15:0] memReadData;
  logic [15:0] outData;
  logic        outValid;
  logic        outReady;

  logic [15:0] mem [0:65535];

  int vectors = 0;
  int errors  = 0;
  int we_bad  = 0;
  int ndone;
  int first_c;
  int gaps;
  logic [15:0] got [$];

  always #5 clk = ~clk;

  // Memory address register is memAddress itself; data follows it.
  assign memReadData = mem[memAddress];

  mem_burst_reader #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (16),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .baseAddress    (baseAddress),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .memAddress     (memAddress),
    .memWriteEnable (memWriteEnable),
    .memReadData    (memReadData),
    .outData        (outData),
    .outValid       (outValid),
    .outReady       (outReady)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [15:0] b, input logic [15:0] n);
    baseAddress = b;
    length      = n;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  // mode 0: ready always; mode 1: ready on every third cycle
  task automatic run(input int maxc, input int mode);
    got.delete();
    ndone   = 0;
    first_c = -1;
    gaps    = 0;
    for (int c = 0; c < maxc; c++) begin
      outReady = (mode == 0) ? 1'b1 : (c % 3 == 0);
      #1;
      if (done) ndone++;
      if (memWriteEnable !== 1'b0) we_bad++;
      if (outValid && outReady) begin
        if (first_c < 0) first_c = c;
        else if (c != first_c + got.size()) gaps++;
        got.push_back(outData);
      end
      if (!busy) break;
      tick();
    end
    chk("run_idle", busy, 1'b0);
    outReady = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    baseAddress = '0;
    length      = '0;
    outReady    = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    mem[10] = 16'd5;
    mem[11] = 16'd6;
    mem[12] = 16'd7;
    mem[13] = 16'd8;
    mem[16'hFFFF] = 16'hAAAA;
    mem[0]        = 16'h5555;
    for (int i = 0; i < 8; i++) mem[30+i] = 16'h3000 + 16'(i);

    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", memAddress, 16'h0);
    chk("rst_valid", outValid, 1'b0);
    chk("rst_we", memWriteEnable, 1'b0);
    reset = 1'b1;
    tick();

    // 1: straight burst, consumer always ready
    kick(16'd10, 16'd4);
    chk("t1_busy", busy, 1'b1);
    chk("t1_addr0", memAddress, 16'h0);
    run(40, 0);
    chk("t1_n", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk("t1_word", got[i], 16'(5 + i));
    end
    chk("t1_first", first_c, 2);
    chk("t1_gaps", gaps, 0);
    chk("t1_done", ndone, 1);

    // 2a: consumer stalled, issue must stop at a full FIFO
    kick(16'd10, 16'd4);
    outReady = 1'b0;
    tick();
    chk("t2_addr1", memAddress, 16'd10);
    for (int i = 0; i < 5; i++) tick();
    chk("t2_stall_addr", memAddress, 16'd11);
    chk("t2_stall_valid", outValid, 1'b1);
    chk("t2_stall_data", outData, 16'd5);
    tick();
    chk("t2_hold_addr", memAddress, 16'd11);
    chk("t2_hold_data", outData, 16'd5);
    run(80, 0);
    chk("t2a_n", got.size(), 4);
    chk("t2a_done", ndone, 1);

    // 2b: toggling ready
    kick(16'd10, 16'd4);
    run(80, 1);
    chk("t2b_n", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk("t2b_word", got[i], 16'(5 + i));
    end
    chk("t2b_done", ndone, 1);

    // 3: empty burst
    chk("t3_pre_addr", memAddress, 16'd13);
    kick(16'd500, 16'd0);
    chk("t3_done", done, 1'b1);
    chk("t3_valid", outValid, 1'b0);
    chk("t3_addr", memAddress, 16'd13);
    tick();
    chk("t3_done_off", done, 1'b0);
    chk("t3_busy_off", busy, 1'b0);
    chk("t3_addr2", memAddress, 16'd13);

    // 4: address wrap
    kick(16'hFFFF, 16'd2);
    run(40, 0);
    chk("t4_n", got.size(), 2);
    if (got.size() == 2) begin
      chk("t4_w0", got[0], 16'hAAAA);
      chk("t4_w1", got[1], 16'h5555);
    end

    // 5: reset in the middle of an 8-word burst
    kick(16'd30, 16'd8);
    outReady = 1'b1;
    tick();
    tick();
    chk("t5_w0", outData, 16'h3000);
    chk("t5_v0", outValid, 1'b1);
    tick();
    chk("t5_w1", outData, 16'h3001);
    reset = 1'b0;
    tick();
    chk("t5_busy", busy, 1'b0);
    chk("t5_valid", outValid, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_addr", memAddress, 16'h0);
    reset    = 1'b1;
    outReady = 1'b0;
    tick();
    kick(16'd10, 16'd1);
    run(40, 0);
    chk("t5_n", got.size(), 1);
    if (got.size() == 1) chk("t5_word", got[0], 16'd5);
    chk("t5_ndone", ndone, 1);

    // 6: start while busy is ignored
    kick(16'd10, 16'd4);
    outReady    = 1'b0;
    start       = 1'b1;
    baseAddress = 16'd30;
    length      = 16'd2;
    tick();
    tick();
    start = 1'b0;
    run(60, 0);
    chk("t6_n", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk("t6_word", got[i], 16'(5 + i));
    end
    chk("t6_done", ndone, 1);
    tick();
    chk("t6_idle", busy, 1'b0);
    chk("we_never", we_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
